axi_lite_write_master: RTL

AXI-Lite write-channel master that sits directly upstream of the AXI-Lite write slave and drives its AW, W and B channels. Local logic pushes address/data write commands into a small command FIFO. The block then issues one AXI-Lite write at a time, waits for the write response, and reports completion or timeout. There is no read channel and no BRESP: the downstream slave returns no response code.

---
 rtl/axi_lite_write_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_write_master.sv
// AXI-Lite write-channel master.
// Local logic queues address/data commands in a small FIFO. The block issues
// them one at a time on AW/W, waits for the B handshake, and pulses done on
// completion or err when the optional per-transaction timeout expires.
module axi_lite_write_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic                          bvalid,
  output logic                          bready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;

  logic        aw_sent, w_sent;
  logic        aw_sent_now, w_sent_now;
  logic [15:0] tmo_cnt;
  logic        b_hs, timeout_hit;

  logic [ADDR_WIDTH-1:0] awaddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic        awvalid_nxt, wvalid_nxt, bready_nxt, done_nxt, err_nxt;
  logic        aw_sent_nxt, w_sent_nxt;
  logic [15:0] tmo_cnt_nxt;

  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  // A channel counts as finished if it already handshook or handshakes now.
  assign aw_sent_now = aw_sent || (awvalid && awready);
  assign w_sent_now  = w_sent  || (wvalid && wready);
  assign b_hs        = bvalid && bready;

  // Timeout fires on the last allowed cycle unless the B handshake wins it.
  assign timeout_hit = TO_EN && (state != IDLE) && (tmo_cnt == TO_LAST) &&
                       !((state == RESP) && b_hs);

  // Command storage; entries need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pop) state_next = ADDR_DATA;
      end
      ADDR_DATA: begin
        if (timeout_hit)                     state_next = IDLE;
        else if (aw_sent_now && w_sent_now)  state_next = RESP;
      end
      RESP: begin
        if (b_hs || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered AXI outputs, status pulses and bookkeeping.
  always_comb begin
    awaddr_nxt  = awaddr;
    wdata_nxt   = wdata;
    awvalid_nxt = awvalid;
    wvalid_nxt  = wvalid;
    bready_nxt  = bready;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    aw_sent_nxt = aw_sent;
    w_sent_nxt  = w_sent;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      IDLE: begin
        if (pop) begin
          awaddr_nxt  = addr_mem[rd_ptr];
          wdata_nxt   = data_mem[rd_ptr];
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          aw_sent_nxt = 1'b0;
          w_sent_nxt  = 1'b0;
          tmo_cnt_nxt = '0;
        end
      end
      ADDR_DATA: begin
        tmo_cnt_nxt = tmo_cnt + 16'd1;
        aw_sent_nxt = aw_sent_now;
        w_sent_nxt  = w_sent_now;
        if (awvalid && awready) awvalid_nxt = 1'b0;
        if (wvalid && wready)   wvalid_nxt  = 1'b0;
        if (timeout_hit) begin
          awvalid_nxt = 1'b0;
          wvalid_nxt  = 1'b0;
          bready_nxt  = 1'b0;
          err_nxt     = 1'b1;
        end else if (aw_sent_now && w_sent_now) begin
          bready_nxt = 1'b1;
        end
      end
      RESP: begin
        tmo_cnt_nxt = tmo_cnt + 16'd1;
        if (b_hs) begin
          bready_nxt = 1'b0;
          done_nxt   = 1'b1;
        end else if (timeout_hit) begin
          bready_nxt = 1'b0;
          err_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      aw_sent <= 1'b0;
      w_sent  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      awaddr  <= awaddr_nxt;
      wdata   <= wdata_nxt;
      awvalid <= awvalid_nxt;
      wvalid  <= wvalid_nxt;
      bready  <= bready_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      aw_sent <= aw_sent_nxt;
      w_sent  <= w_sent_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

endmodule
